ras_nwide_ckpt: RTL and testbench



---
 rtl/ras_nwide_ckpt.sv | 103 ++++++++++
 tb/tb_ras_nwide_ckpt.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ras_nwide_ckpt.sv
// ras_nwide_ckpt: N-wide return address stack with per-branch checkpoints of {ptr, cnt, top}
module ras_nwide_ckpt #(
  parameter int XLEN = 32,
  parameter int WIDTH = 2,
  parameter int DEPTH = 32,
  parameter int NUM_CKPT = 8
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [WIDTH-1:0][XLEN-1:0]        PC,
  input  logic [WIDTH-1:0]                  is_valid,
  input  logic [WIDTH-1:0]                  is_call,
  input  logic [WIDTH-1:0]                  is_return,
  input  logic                              ckpt_take,
  input  logic [$clog2(NUM_CKPT)-1:0]       ckpt_id,
  input  logic                              recover,
  input  logic [$clog2(NUM_CKPT)-1:0]       recover_id,
  output logic [XLEN-1:0]                   return_PC,
  output logic                              return_hit,
  output logic [$clog2(DEPTH+1)-1:0]        count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [XLEN-1:0] mem [DEPTH];
  logic [PW-1:0] ptr, r_ptr;
  logic [CW-1:0] cnt, r_cnt;
  logic [XLEN-1:0] r_top, hit_pc, base;
  logic hit, done;
  logic [WIDTH-1:0] wen;
  logic [WIDTH-1:0][PW-1:0] widx;
  logic [WIDTH-1:0][XLEN-1:0] wdata;
  logic [PW-1:0] ck_ptr [NUM_CKPT];
  logic [CW-1:0] ck_cnt [NUM_CKPT];
  logic [XLEN-1:0] ck_top [NUM_CKPT];
  always_comb begin
    r_ptr = ptr;
    r_cnt = cnt;
    r_top = mem[ptr - 1'b1];
    hit = 1'b0;
    hit_pc = '0;
    done = 1'b0;
    wen = '0;
    widx = '0;
    wdata = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (is_valid[i] && !done) begin
        if (is_return[i]) begin
          done = 1'b1;
          if (r_cnt != '0) begin
            hit = 1'b1;
            hit_pc = r_top;
            r_ptr = r_ptr - 1'b1;
            r_cnt = r_cnt - 1'b1;
            r_top = mem[r_ptr - 1'b1];
            // new top may have been pushed earlier in this same group
            for (int j = 0; j < WIDTH; j++)
              if (wen[j] && widx[j] == r_ptr - 1'b1) r_top = wdata[j];
          end
        end
        if (is_call[i]) begin
          wen[i] = 1'b1;
          widx[i] = r_ptr;
          wdata[i] = PC[i] + XLEN'(4);
          r_ptr = r_ptr + 1'b1;
          r_cnt = (r_cnt == FULL) ? r_cnt : r_cnt + 1'b1;
          r_top = wdata[i];
        end
      end
    end
  end
  assign base = PC[0] + XLEN'(4 * WIDTH);
  assign return_hit = hit && !recover && !reset;
  assign return_PC = return_hit ? hit_pc : base;
  assign count = cnt;
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      for (int i = 0; i < NUM_CKPT; i++) begin
        ck_ptr[i] <= '0;
        ck_cnt[i] <= '0;
        ck_top[i] <= '0;
      end
    end else if (recover) begin
      ptr <= ck_ptr[recover_id];
      cnt <= ck_cnt[recover_id];
      // younger pushes may have overwritten the saved top entry
      if (ck_cnt[recover_id] != '0) mem[ck_ptr[recover_id] - 1'b1] <= ck_top[recover_id];
    end else begin
      ptr <= r_ptr;
      cnt <= r_cnt;
      for (int i = 0; i < WIDTH; i++)
        if (wen[i]) mem[widx[i]] <= wdata[i];
      if (ckpt_take) begin
        ck_ptr[ckpt_id] <= r_ptr;
        ck_cnt[ckpt_id] <= r_cnt;
        ck_top[ckpt_id] <= r_top;
      end
    end
  end
endmodule

// File: tb/tb_ras_nwide_ckpt.sv
// tb_ras_nwide_ckpt: directed vector table, hand-written checkpoint/reset sequences, and a
// randomized run compared against a circular-array stack model.
module tb_ras_nwide_ckpt;
  localparam int X = 32, W = 2, D = 4, NC = 8;
  typedef struct {
    logic rst;
    logic [31:0] pc0, pc1;
    logic [1:0] v, c, r;
    logic tk;
    logic [2:0] cid;
    logic rc;
    logic [2:0] rid;
    logic hit;
    logic [31:0] epc;
    logic [2:0] ecnt;
  } vec_t;
  logic clock = 1'b0;
  logic reset;
  logic [W-1:0][X-1:0] pc;
  logic [W-1:0] is_valid, is_call, is_return;
  logic ckpt_take, recover;
  logic [2:0] ckpt_id, recover_id;
  logic [X-1:0] return_PC;
  logic return_hit;
  logic [2:0] count;
  int n_chk = 0, n_fail = 0;
  logic [31:0] m_mem [D];
  int m_sp, m_cnt;
  int k_sp [NC], k_cnt [NC];
  logic [31:0] k_top [NC];
  vec_t tbl [$];

  always #5 clock = ~clock;

  ras_nwide_ckpt #(.XLEN(X), .WIDTH(W), .DEPTH(D), .NUM_CKPT(NC)) dut (
    .clock(clock), .reset(reset), .PC(pc), .is_valid(is_valid), .is_call(is_call),
    .is_return(is_return), .ckpt_take(ckpt_take), .ckpt_id(ckpt_id), .recover(recover),
    .recover_id(recover_id), .return_PC(return_PC), .return_hit(return_hit), .count(count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic [31:0] pc0, input logic [31:0] pc1,
                              input logic [1:0] v, input logic [1:0] c, input logic [1:0] r,
                              input logic tk, input logic [2:0] cid, input logic rc,
                              input logic [2:0] rid, input logic hit, input logic [31:0] epc,
                              input logic [2:0] ecnt);
    vec_t t;
    t.rst = rst; t.pc0 = pc0; t.pc1 = pc1; t.v = v; t.c = c; t.r = r;
    t.tk = tk; t.cid = cid; t.rc = rc; t.rid = rid; t.hit = hit; t.epc = epc; t.ecnt = ecnt;
    return t;
  endfunction

  function automatic vec_t cl(input logic [31:0] p, input logic [2:0] n);
    return mk(1'b0, p, p + 32'd4, 2'b01, 2'b01, 2'b00, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, p + 32'd8, n);
  endfunction

  function automatic vec_t rt(input logic [31:0] p, input logic h, input logic [31:0] e, input logic [2:0] n);
    return mk(1'b0, p, p + 32'd4, 2'b01, 2'b00, 2'b01, 1'b0, 3'd0, 1'b0, 3'd0, h, e, n);
  endfunction

  function automatic vec_t nop(input logic [2:0] n);
    return mk(1'b0, 32'h0, 32'h0, 2'b00, 2'b00, 2'b00, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 32'h8, n);
  endfunction

  task automatic drive(input vec_t v);
    reset = v.rst;
    pc[0] = v.pc0;
    pc[1] = v.pc1;
    is_valid = v.v;
    is_call = v.c;
    is_return = v.r;
    ckpt_take = v.tk;
    ckpt_id = v.cid;
    recover = v.rc;
    recover_id = v.rid;
  endtask

  task automatic step(input string name, input vec_t v);
    drive(v);
    @(negedge clock);
    chk({name, ".hit"}, {31'b0, return_hit}, {31'b0, v.hit});
    chk({name, ".pc"}, return_PC, v.epc);
    chk({name, ".cnt"}, {29'b0, count}, {29'b0, v.ecnt});
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [31:0] val);
    m_mem[m_sp] = val;
    m_sp = (m_sp + 1) % D;
    if (m_cnt < D) m_cnt++;
  endtask

  // Applies the stack rules slot by slot on the model; returns this cycle's expected outputs.
  task automatic model(output logic e_hit, output logic [31:0] e_pc, output int e_cnt);
    e_hit = 1'b0;
    e_pc = pc[0] + 32'(4 * W);
    e_cnt = m_cnt;
    if (reset) begin
      m_sp = 0;
      m_cnt = 0;
      for (int k = 0; k < D; k++) m_mem[k] = '0;
      for (int k = 0; k < NC; k++) begin k_sp[k] = 0; k_cnt[k] = 0; k_top[k] = '0; end
      return;
    end
    if (recover) begin
      m_sp = k_sp[recover_id];
      m_cnt = k_cnt[recover_id];
      if (m_cnt > 0) m_mem[(m_sp + D - 1) % D] = k_top[recover_id];
      return;
    end
    for (int s = 0; s < W; s++) begin
      if (is_valid[s]) begin
        if (is_return[s]) begin
          if (m_cnt > 0) begin
            e_hit = 1'b1;
            m_sp = (m_sp + D - 1) % D;
            e_pc = m_mem[m_sp];
            m_cnt--;
          end
          if (is_call[s]) push(pc[s] + 32'd4);
          break;
        end
        if (is_call[s]) push(pc[s] + 32'd4);
      end
    end
    if (ckpt_take) begin
      k_sp[ckpt_id] = m_sp;
      k_cnt[ckpt_id] = m_cnt;
      k_top[ckpt_id] = m_mem[(m_sp + D - 1) % D];
    end
  endtask

  initial begin
    logic eh;
    logic [31:0] ep;
    int ec;
    drive(mk(1'b1, 32'h40, 32'h44, 2'b11, 2'b00, 2'b01, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 32'h48, 3'd0));
    @(posedge clock);
    step("reset", mk(1'b1, 32'h40, 32'h44, 2'b11, 2'b00, 2'b01, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 32'h48, 3'd0));

    tbl.push_back(mk(1'b0, 32'h100, 32'h104, 2'b11, 2'b01, 2'b10, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 32'h104, 3'd0));
    tbl.push_back(nop(3'd0));
    tbl.push_back(cl(32'h200, 3'd0));
    tbl.push_back(cl(32'h300, 3'd1));
    tbl.push_back(rt(32'h400, 1'b1, 32'h304, 3'd2));
    tbl.push_back(rt(32'h410, 1'b1, 32'h204, 3'd1));
    for (int k = 0; k < 6; k++) tbl.push_back(cl(32'h10 * (k + 1), (k < 4) ? 3'(k) : 3'd4));
    tbl.push_back(rt(32'h70, 1'b1, 32'h64, 3'd4));
    tbl.push_back(rt(32'h70, 1'b1, 32'h54, 3'd3));
    tbl.push_back(rt(32'h70, 1'b1, 32'h44, 3'd2));
    tbl.push_back(rt(32'h70, 1'b1, 32'h34, 3'd1));
    tbl.push_back(rt(32'h80, 1'b0, 32'h88, 3'd0));
    tbl.push_back(cl(32'h90, 3'd0));
    tbl.push_back(rt(32'h98, 1'b1, 32'h94, 3'd1));
    tbl.push_back(cl(32'h700, 3'd0));
    tbl.push_back(cl(32'h100, 3'd1));
    tbl.push_back(mk(1'b0, 32'h500, 32'h504, 2'b01, 2'b01, 2'b01, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 32'h104, 3'd2));
    tbl.push_back(rt(32'h600, 1'b1, 32'h504, 3'd2));
    tbl.push_back(rt(32'h610, 1'b1, 32'h704, 3'd1));
    tbl.push_back(mk(1'b0, 32'hA00, 32'hA04, 2'b01, 2'b01, 2'b00, 1'b1, 3'd3, 1'b0, 3'd0, 1'b0, 32'hA08, 3'd0));
    tbl.push_back(rt(32'hB00, 1'b1, 32'hA04, 3'd1));
    tbl.push_back(cl(32'hF00, 3'd0));
    tbl.push_back(mk(1'b0, 32'hC00, 32'hC04, 2'b01, 2'b00, 2'b01, 1'b0, 3'd0, 1'b1, 3'd3, 1'b0, 32'hC08, 3'd1));
    tbl.push_back(rt(32'hD00, 1'b1, 32'hA04, 3'd1));
    tbl.push_back(cl(32'hE00, 3'd0));
    tbl.push_back(mk(1'b0, 32'hE10, 32'hE14, 2'b01, 2'b01, 2'b00, 1'b0, 3'd0, 1'b1, 3'd5, 1'b0, 32'hE18, 3'd1));
    tbl.push_back(rt(32'hE20, 1'b0, 32'hE28, 3'd0));
    tbl.push_back(mk(1'b0, 32'h300, 32'h304, 2'b10, 2'b01, 2'b10, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 32'h308, 3'd0));
    tbl.push_back(nop(3'd0));
    foreach (tbl[k]) step($sformatf("row%0d", k), tbl[k]);

    // reset in the same cycle as recover must win, and clears the checkpoint
    step("rw0", mk(1'b0, 32'h1000, 32'h1004, 2'b01, 2'b01, 2'b00, 1'b1, 3'd1, 1'b0, 3'd0, 1'b0, 32'h1008, 3'd0));
    step("rw1", mk(1'b1, 32'h1100, 32'h1104, 2'b01, 2'b00, 2'b01, 1'b0, 3'd0, 1'b1, 3'd1, 1'b0, 32'h1108, 3'd1));
    step("rw2", nop(3'd0));
    step("rw3", mk(1'b0, 32'h1200, 32'h1204, 2'b00, 2'b00, 2'b00, 1'b0, 3'd0, 1'b1, 3'd1, 1'b0, 32'h1208, 3'd0));
    step("rw4", nop(3'd0));

    // ckpt_take during a recover cycle must not overwrite the slot
    step("ci0", mk(1'b0, 32'h2000, 32'h2004, 2'b01, 2'b01, 2'b00, 1'b1, 3'd2, 1'b0, 3'd0, 1'b0, 32'h2008, 3'd0));
    step("ci1", cl(32'h2100, 3'd1));
    step("ci2", mk(1'b0, 32'h2200, 32'h2204, 2'b01, 2'b01, 2'b00, 1'b1, 3'd2, 1'b1, 3'd2, 1'b0, 32'h2208, 3'd2));
    step("ci3", rt(32'h2300, 1'b1, 32'h2004, 3'd1));
    step("ci4", mk(1'b0, 32'h2400, 32'h2404, 2'b00, 2'b00, 2'b00, 1'b0, 3'd0, 1'b1, 3'd2, 1'b0, 32'h2408, 3'd0));
    step("ci5", rt(32'h2500, 1'b1, 32'h2004, 3'd1));

    m_sp = 0;
    m_cnt = 0;
    for (int i = 0; i < 600; i++) begin
      reset = (i == 0) || ($urandom_range(0, 59) == 0);
      for (int s = 0; s < W; s++)
        pc[s] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      is_valid = 2'($urandom_range(0, 3));
      is_call = 2'($urandom_range(0, 3));
      is_return = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      ckpt_take = ($urandom_range(0, 2) == 0);
      ckpt_id = 3'($urandom_range(0, NC - 1));
      recover = ($urandom_range(0, 11) == 0);
      recover_id = 3'($urandom_range(0, NC - 1));
      model(eh, ep, ec);
      @(negedge clock);
      chk($sformatf("rnd%0d.hit", i), {31'b0, return_hit}, {31'b0, eh});
      chk($sformatf("rnd%0d.pc", i), return_PC, ep);
      if (i > 0) chk($sformatf("rnd%0d.cnt", i), {29'b0, count}, 32'(ec));
      @(posedge clock);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
